jtag_tap_controller: RTL and testbench

IEEE 1149.1 TAP controller and instruction register for the RD53A end-of-column JTAG port. It sits directly upstream of the JTAG data registers: it decodes TMS into CAPTURE_DR, SHIFT_DR and UPDATE_DR, which every data-register instance consumes, and holds the active instruction. It also owns the 1-bit BYPASS register and the negedge-retimed TDO output multiplexer. The same TCK net drives this block and the CLOCK_DR pins of all data registers.

---
 rtl/jtag_tap_controller.sv | 156 +++++++++++++++
 tb/tb_jtag_tap_controller.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller with instruction register, BYPASS register
// and negedge-retimed TDO output for the RD53A end-of-column JTAG port.
module jtag_tap_controller #(
    parameter int unsigned         IR_WIDTH   = 5,
    parameter logic [IR_WIDTH-1:0] IR_RESET   = 5'b00001,
    parameter logic [IR_WIDTH-1:0] IR_CAPTURE = 5'b00001
) (
    input  logic                TCK,
    input  logic                RESET,
    input  logic                TMS,
    input  logic                TDI,
    input  logic                DR_TDO,
    output logic                TDO,
    output logic                TDO_EN,
    output logic [3:0]          STATE,
    output logic                TEST_LOGIC_RESET,
    output logic                RUN_TEST_IDLE,
    output logic                CAPTURE_DR,
    output logic                SHIFT_DR,
    output logic                UPDATE_DR,
    output logic                CAPTURE_IR,
    output logic                SHIFT_IR,
    output logic                UPDATE_IR,
    output logic [IR_WIDTH-1:0] INSTRUCTION,
    output logic                BYPASS_SEL
);

    typedef enum logic [3:0] {
        TLR     = 4'hF,
        RTI     = 4'hC,
        SEL_DR  = 4'h7,
        CAP_DR  = 4'h6,
        SH_DR   = 4'h2,
        EX1_DR  = 4'h1,
        PAU_DR  = 4'h3,
        EX2_DR  = 4'h0,
        UPD_DR  = 4'h5,
        SEL_IR  = 4'h4,
        CAP_IR  = 4'hE,
        SH_IR   = 4'hA,
        EX1_IR  = 4'h9,
        PAU_IR  = 4'hB,
        EX2_IR  = 4'h8,
        UPD_IR  = 4'hD
    } tap_state_e;

    tap_state_e          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
    logic [IR_WIDTH-1:0] instruction_q, instruction_d;
    logic                bypass_q, bypass_d;
    logic                tdo_q, tdo_d;
    logic                tdo_en_q, tdo_en_d;
    logic                bypass_sel;

    always_ff @(posedge TCK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= TLR;
            ir_sr_q  <= IR_CAPTURE;
            bypass_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_sr_q  <= ir_sr_d;
            bypass_q <= bypass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:     state_d = TMS ? TLR    : RTI;
            RTI:     state_d = TMS ? SEL_DR : RTI;
            SEL_DR:  state_d = TMS ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = TMS ? EX1_DR : SH_DR;
            SH_DR:   state_d = TMS ? EX1_DR : SH_DR;
            EX1_DR:  state_d = TMS ? UPD_DR : PAU_DR;
            PAU_DR:  state_d = TMS ? EX2_DR : PAU_DR;
            EX2_DR:  state_d = TMS ? UPD_DR : SH_DR;
            UPD_DR:  state_d = TMS ? SEL_DR : RTI;
            SEL_IR:  state_d = TMS ? TLR    : CAP_IR;
            CAP_IR:  state_d = TMS ? EX1_IR : SH_IR;
            SH_IR:   state_d = TMS ? EX1_IR : SH_IR;
            EX1_IR:  state_d = TMS ? UPD_IR : PAU_IR;
            PAU_IR:  state_d = TMS ? EX2_IR : PAU_IR;
            EX2_IR:  state_d = TMS ? UPD_IR : SH_IR;
            UPD_IR:  state_d = TMS ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Flags decode the registered state only, so TMS never reaches an output.
    always_comb begin
        STATE            = state_q;
        TEST_LOGIC_RESET = (state_q == TLR);
        RUN_TEST_IDLE    = (state_q == RTI);
        CAPTURE_DR       = (state_q == CAP_DR);
        SHIFT_DR         = (state_q == SH_DR);
        UPDATE_DR        = (state_q == UPD_DR);
        CAPTURE_IR       = (state_q == CAP_IR);
        SHIFT_IR         = (state_q == SH_IR);
        UPDATE_IR        = (state_q == UPD_IR);
        bypass_sel       = &instruction_q;
        BYPASS_SEL       = bypass_sel;
        INSTRUCTION      = instruction_q;
        TDO              = tdo_q;
        TDO_EN           = tdo_en_q;
    end

    always_comb begin
        ir_sr_d  = ir_sr_q;
        bypass_d = bypass_q;
        if (state_q == CAP_IR) begin
            ir_sr_d = IR_CAPTURE;
        end else if (state_q == SH_IR) begin
            ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
        end
        if (bypass_sel) begin
            if (state_q == CAP_DR) begin
                bypass_d = 1'b0;
            end else if (state_q == SH_DR) begin
                bypass_d = TDI;
            end
        end
    end

    // Falling-edge side: shadow load mid-update and TDO retiming for the remote sampler.
    always_comb begin
        instruction_d = instruction_q;
        tdo_d         = 1'b0;
        tdo_en_d      = 1'b0;
        if (state_q == UPD_IR) begin
            instruction_d = ir_sr_q;
        end else if (state_q == TLR) begin
            instruction_d = IR_RESET;
        end
        if (state_q == SH_IR) begin
            tdo_d    = ir_sr_q[0];
            tdo_en_d = 1'b1;
        end else if (state_q == SH_DR) begin
            tdo_d    = bypass_sel ? bypass_q : DR_TDO;
            tdo_en_d = 1'b1;
        end
    end

    always_ff @(negedge TCK or negedge RESET) begin
        if (!RESET) begin
            instruction_q <= IR_RESET;
            tdo_q         <= 1'b0;
            tdo_en_q      <= 1'b0;
        end else begin
            instruction_q <= instruction_d;
            tdo_q         <= tdo_d;
            tdo_en_q      <= tdo_en_d;
        end
    end

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Self-checking bench for jtag_tap_controller: directed scenarios plus a
// randomized TMS/TDI walk compared against a table-driven TAP model.
module tb_jtag_tap_controller;

    localparam int unsigned IRW = 5;

    localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SDR = 4'h7, S_CDR = 4'h6,
                           S_HDR = 4'h2, S_E1D = 4'h1, S_PDR = 4'h3, S_E2D = 4'h0,
                           S_UDR = 4'h5, S_SIR = 4'h4, S_CIR = 4'hE, S_HIR = 4'hA,
                           S_E1I = 4'h9, S_PIR = 4'hB, S_E2I = 4'h8, S_UIR = 4'hD;

    logic           TCK = 1'b0;
    logic           RESET, TMS, TDI, DR_TDO;
    logic           TDO, TDO_EN;
    logic [3:0]     STATE;
    logic           TEST_LOGIC_RESET, RUN_TEST_IDLE;
    logic           CAPTURE_DR, SHIFT_DR, UPDATE_DR;
    logic           CAPTURE_IR, SHIFT_IR, UPDATE_IR;
    logic [IRW-1:0] INSTRUCTION;
    logic           BYPASS_SEL;

    int checks = 0;
    int errors = 0;

    jtag_tap_controller #(
        .IR_WIDTH  (5),
        .IR_RESET  (5'b00001),
        .IR_CAPTURE(5'b00001)
    ) dut (
        .TCK             (TCK),
        .RESET           (RESET),
        .TMS             (TMS),
        .TDI             (TDI),
        .DR_TDO          (DR_TDO),
        .TDO             (TDO),
        .TDO_EN          (TDO_EN),
        .STATE           (STATE),
        .TEST_LOGIC_RESET(TEST_LOGIC_RESET),
        .RUN_TEST_IDLE   (RUN_TEST_IDLE),
        .CAPTURE_DR      (CAPTURE_DR),
        .SHIFT_DR        (SHIFT_DR),
        .UPDATE_DR       (UPDATE_DR),
        .CAPTURE_IR      (CAPTURE_IR),
        .SHIFT_IR        (SHIFT_IR),
        .UPDATE_IR       (UPDATE_IR),
        .INSTRUCTION     (INSTRUCTION),
        .BYPASS_SEL      (BYPASS_SEL)
    );

    always #5 TCK = ~TCK;

    // Reference model: transition table plus register contents
    logic [3:0]     nxt0 [16];
    logic [3:0]     nxt1 [16];
    logic [3:0]     m_state;
    logic [IRW-1:0] m_ir, m_instr;
    logic           m_byp, m_tdo, m_tdo_en;

    task automatic build_table();
        nxt0[S_TLR] = S_RTI; nxt1[S_TLR] = S_TLR;
        nxt0[S_RTI] = S_RTI; nxt1[S_RTI] = S_SDR;
        nxt0[S_SDR] = S_CDR; nxt1[S_SDR] = S_SIR;
        nxt0[S_SIR] = S_CIR; nxt1[S_SIR] = S_TLR;
        nxt0[S_CDR] = S_HDR; nxt1[S_CDR] = S_E1D;
        nxt0[S_HDR] = S_HDR; nxt1[S_HDR] = S_E1D;
        nxt0[S_E1D] = S_PDR; nxt1[S_E1D] = S_UDR;
        nxt0[S_PDR] = S_PDR; nxt1[S_PDR] = S_E2D;
        nxt0[S_E2D] = S_HDR; nxt1[S_E2D] = S_UDR;
        nxt0[S_UDR] = S_RTI; nxt1[S_UDR] = S_SDR;
        nxt0[S_CIR] = S_HIR; nxt1[S_CIR] = S_E1I;
        nxt0[S_HIR] = S_HIR; nxt1[S_HIR] = S_E1I;
        nxt0[S_E1I] = S_PIR; nxt1[S_E1I] = S_UIR;
        nxt0[S_PIR] = S_PIR; nxt1[S_PIR] = S_E2I;
        nxt0[S_E2I] = S_HIR; nxt1[S_E2I] = S_UIR;
        nxt0[S_UIR] = S_RTI; nxt1[S_UIR] = S_SDR;
    endtask

    task automatic model_reset();
        m_state  = S_TLR;
        m_ir     = 5'b00001;
        m_instr  = 5'b00001;
        m_byp    = 1'b0;
        m_tdo    = 1'b0;
        m_tdo_en = 1'b0;
    endtask

    task automatic model_rise(input logic tms, input logic tdi);
        if (m_state == S_CIR) m_ir = 5'b00001;
        else if (m_state == S_HIR) m_ir = {tdi, m_ir[IRW-1:1]};
        if (m_instr == 5'b11111) begin
            if (m_state == S_CDR) m_byp = 1'b0;
            else if (m_state == S_HDR) m_byp = tdi;
        end
        m_state = tms ? nxt1[m_state] : nxt0[m_state];
    endtask

    task automatic model_fall(input logic dr);
        m_tdo_en = (m_state == S_HIR) || (m_state == S_HDR);
        if (m_state == S_HIR) m_tdo = m_ir[0];
        else if (m_state == S_HDR) m_tdo = (m_instr == 5'b11111) ? m_byp : dr;
        else m_tdo = 1'b0;
        if (m_state == S_UIR) m_instr = m_ir;
        else if (m_state == S_TLR) m_instr = 5'b00001;
    endtask

    function automatic logic [19:0] obs_dut();
        return {STATE, TEST_LOGIC_RESET, RUN_TEST_IDLE, CAPTURE_DR, SHIFT_DR, UPDATE_DR,
                CAPTURE_IR, SHIFT_IR, UPDATE_IR, TDO, TDO_EN, INSTRUCTION, BYPASS_SEL};
    endfunction

    function automatic logic [19:0] obs_mdl();
        return {m_state, m_state == S_TLR, m_state == S_RTI, m_state == S_CDR,
                m_state == S_HDR, m_state == S_UDR, m_state == S_CIR, m_state == S_HIR,
                m_state == S_UIR, m_tdo, m_tdo_en, m_instr, m_instr == 5'b11111};
    endfunction

    // One TCK period; entered and left 1 ns after a falling edge.
    task automatic step(input logic tms, input logic tdi, input logic dr);
        TMS = tms; TDI = tdi; DR_TDO = dr;
        @(posedge TCK);
        model_rise(tms, tdi);
        @(negedge TCK);
        model_fall(dr);
        #1;
    endtask

    task automatic load_ir(input logic [IRW-1:0] v);
        step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        for (int j = 0; j < 5; j++) step(j == 4, v[j], 0);
        step(1, 0, 0); step(0, 0, 0);
    endtask

    task automatic test_reset_values();
        checks++;
        if (obs_dut() !== {4'hF, 8'b1000_0000, 2'b00, 5'b00001, 1'b0})
            $display("FAIL reset_values got=%h exp=%h", obs_dut(),
                     {4'hF, 8'b1000_0000, 2'b00, 5'b00001, 1'b0});
        if (obs_dut() !== {4'hF, 8'b1000_0000, 2'b00, 5'b00001, 1'b0}) errors++;
    endtask

    task automatic test_reset();
        step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0); step(0, 1, 0);
        RESET = 1'b0;
        #2;
        checks++;
        if (STATE !== 4'hF || INSTRUCTION !== 5'b00001 || TDO_EN !== 1'b0 || TDO !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_shift state=%h instr=%b tdo_en=%b tdo=%b exp F 00001 0 0",
                     STATE, INSTRUCTION, TDO_EN, TDO);
        end
        model_reset();
        @(negedge TCK);
        #1;
        RESET = 1'b1;
        step(0, 0, 0);
        checks++;
        if (STATE !== 4'hC) begin
            errors++;
            $display("FAIL reset_release state=%h exp=C", STATE);
        end
    endtask

    task automatic test_ir_load();
        logic [4:0] obs;
        step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        obs[0] = TDO;
        for (int j = 0; j < 5; j++) begin
            logic [4:0] v;
            v = 5'b10110;
            step(j == 4, v[j], 0);
            if (j < 4) obs[j+1] = TDO;
        end
        checks++;
        if (obs !== 5'b00001) begin
            errors++;
            $display("FAIL ir_capture_stream got=%b exp=00001 (bit0 first)", obs);
        end
        step(1, 0, 0);
        checks++;
        if (UPDATE_IR !== 1'b1 || INSTRUCTION !== 5'b10110) begin
            errors++;
            $display("FAIL ir_update upd=%b instr=%b exp 1 10110", UPDATE_IR, INSTRUCTION);
        end
        step(0, 0, 0);
    endtask

    task automatic test_dr_path();
        int sh_cnt = 0;
        int upd_cnt = 0;
        logic dr;
        load_ir(5'b00010);
        checks++;
        if (BYPASS_SEL !== 1'b0 || INSTRUCTION !== 5'b00010) begin
            errors++;
            $display("FAIL dr_select bypass_sel=%b instr=%b exp 0 00010", BYPASS_SEL, INSTRUCTION);
        end
        step(1, 0, 0); step(0, 0, 0);
        checks++;
        if (CAPTURE_DR !== 1'b1) begin
            errors++;
            $display("FAIL capture_dr got=%b exp=1", CAPTURE_DR);
        end
        for (int i = 0; i < 16; i++) begin
            dr = (i % 2 == 0) ^ 1'($urandom_range(0, 1));
            step(0, 0, dr);
            if (SHIFT_DR === 1'b1) sh_cnt++;
            checks++;
            if (TDO !== dr || TDO_EN !== 1'b1) begin
                errors++;
                $display("FAIL dr_tdo[%0d] tdo=%b en=%b exp %b 1", i, TDO, TDO_EN, dr);
            end
        end
        step(1, 0, 1);
        if (SHIFT_DR === 1'b1) sh_cnt++;
        checks++;
        if (sh_cnt != 16 || TDO !== 1'b0) begin
            errors++;
            $display("FAIL shift_dr_count got=%0d tdo=%b exp 16 0", sh_cnt, TDO);
        end
        step(1, 0, 0);
        if (UPDATE_DR === 1'b1) upd_cnt++;
        step(0, 0, 0);
        if (UPDATE_DR === 1'b1) upd_cnt++;
        checks++;
        if (upd_cnt != 1 || STATE !== 4'hC) begin
            errors++;
            $display("FAIL update_dr_pulse got=%0d state=%h exp 1 C", upd_cnt, STATE);
        end
    endtask

    task automatic test_bypass();
        logic [7:0] bits, obs;
        bits = 8'b10110011;
        load_ir(5'b11111);
        checks++;
        if (BYPASS_SEL !== 1'b1) begin
            errors++;
            $display("FAIL bypass_sel got=%b exp=1", BYPASS_SEL);
        end
        step(1, 0, 0); step(0, 1, 0); step(0, 1, 1);
        obs[0] = TDO;
        for (int j = 0; j < 8; j++) begin
            step(j == 7, bits[7-j], 1);
            if (j < 7) obs[j+1] = TDO;
        end
        checks++;
        if (obs !== 8'b1001_1010) begin
            errors++;
            $display("FAIL bypass_stream got=%b exp=10011010 (bit0 first)", obs);
        end
        step(1, 0, 0); step(0, 0, 0);
    endtask

    task automatic test_pause_resume();
        logic [7:0] p, obs;
        int k = 1;
        p = 8'($urandom);
        step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        obs[0] = TDO;
        for (int j = 0; j < 4; j++) begin
            step(j == 3, p[j], 0);
            if (j < 3) begin obs[k] = TDO; k++; end
        end
        for (int j = 0; j < 3; j++) begin
            step(0, 1, 0);
            checks++;
            if (STATE !== 4'hB || TDO_EN !== 1'b0) begin
                errors++;
                $display("FAIL pause_ir[%0d] state=%h en=%b exp B 0", j, STATE, TDO_EN);
            end
        end
        step(1, 1, 0); step(0, 1, 0);
        obs[k] = TDO; k++;
        for (int j = 4; j < 8; j++) begin
            step(j == 7, p[j], 0);
            if (j < 7) begin obs[k] = TDO; k++; end
        end
        checks++;
        if (obs !== {p[2:0], 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL pause_stream got=%b exp=%b", obs, {p[2:0], 4'b0000, 1'b1});
        end
        step(1, 0, 0);
        checks++;
        if (INSTRUCTION !== p[7:3]) begin
            errors++;
            $display("FAIL pause_instr got=%b exp=%b", INSTRUCTION, p[7:3]);
        end
        step(0, 0, 0);
    endtask

    task automatic test_tlr_recovery();
        load_ir(5'b10110);
        step(1, 0, 0); step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
        checks++;
        if (STATE !== 4'h3) begin
            errors++;
            $display("FAIL reach_pause_dr state=%h exp=3", STATE);
        end
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        checks++;
        if (STATE !== 4'hF || INSTRUCTION !== 5'b00001 || TEST_LOGIC_RESET !== 1'b1) begin
            errors++;
            $display("FAIL tlr_recovery state=%h instr=%b tlr=%b exp F 00001 1",
                     STATE, INSTRUCTION, TEST_LOGIC_RESET);
        end
        step(0, 0, 0);
    endtask

    task automatic test_random();
        int run = 0;
        logic tms, tdi, dr;
        for (int i = 0; i < 800; i++) begin
            tms = 1'($urandom_range(0, 1));
            tdi = ($urandom_range(0, 3) != 0);
            dr  = 1'($urandom_range(0, 1));
            step(tms, tdi, dr);
            run = tms ? run + 1 : 0;
            checks++;
            if (obs_dut() !== obs_mdl()) begin
                errors++;
                $display("FAIL random[%0d] got=%h exp=%h", i, obs_dut(), obs_mdl());
            end
            if (run >= 5) begin
                checks++;
                if (STATE !== 4'hF) begin
                    errors++;
                    $display("FAIL five_tms_ones[%0d] state=%h exp=F", i, STATE);
                end
            end
        end
    endtask

    initial begin
        build_table();
        model_reset();
        RESET = 1'b0; TMS = 1'b1; TDI = 1'b0; DR_TDO = 1'b0;
        @(negedge TCK);
        @(negedge TCK);
        #1;
        test_reset_values();
        RESET = 1'b1;
        step(0, 0, 0);
        test_reset();
        test_ir_load();
        test_dr_path();
        test_bypass();
        test_pause_resume();
        test_tlr_recovery();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
